// File: rtl/pll_lock_supervisor.sv
// Per-channel sequencer for SB_PLL40 reset/bypass, LOCK filtering, timeout retry
// and DYNAMICDELAY ownership. Every output is a register one stage behind the FSM.
module pll_lock_supervisor #(
  parameter int         NCH          = 2,
  parameter int         RST_CYCLES   = 16,
  parameter int         LOCK_FILT    = 64,
  parameter int         LOCK_TIMEOUT = 4096,
  parameter int         MAX_RETRY    = 3,
  parameter logic [7:0] DLY_INIT     = 8'h00
) (
  input  logic             CLK,
  input  logic             RESETB,
  input  logic [NCH-1:0]   ENABLE,
  input  logic [NCH-1:0]   LOCK_IN,
  input  logic             DLY_WE,
  input  logic [1:0]       DLY_CH,
  input  logic [7:0]       DLY_DATA,
  output logic [NCH-1:0]   PLL_RESETB,
  output logic [NCH-1:0]   BYPASS,
  output logic [8*NCH-1:0] DYNAMICDELAY,
  output logic [NCH-1:0]   LOCKED,
  output logic [NCH-1:0]   FAULT
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam int FC_W = $clog2(LOCK_FILT + 1);
  localparam int TC_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int RT_W = $clog2(MAX_RETRY + 1);

  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(LOCK_FILT - 1);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(LOCK_TIMEOUT - 1);
  localparam logic [RT_W-1:0] RT_LAST = RT_W'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    ST_OFF, ST_RESET, ST_WAIT, ST_LOCKED, ST_FAULT
  } state_t;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_t          r_state, w_state_nxt;
    logic            r_sync1, r_sync2;
    logic [RC_W-1:0] r_rst_cnt, w_rst_cnt_nxt;
    logic [FC_W-1:0] r_flt_cnt, w_flt_cnt_nxt;
    logic [TC_W-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
    logic [RT_W-1:0] r_retry, w_retry_nxt;
    logic [7:0]      r_dly, r_dly_o;
    logic            r_rstb_o, r_byp_o, r_lck_o, r_flt_o;
    logic            w_wr;

    // Writes to channels >= NCH never match any channel and are dropped.
    assign w_wr = DLY_WE && (DLY_CH == 2'(c));

    always_ff @(posedge CLK or negedge RESETB) begin
      if (!RESETB) begin
        r_state   <= ST_OFF;
        r_sync1   <= 1'b0;
        r_sync2   <= 1'b0;
        r_rst_cnt <= '0;
        r_flt_cnt <= '0;
        r_tmo_cnt <= '0;
        r_retry   <= '0;
        r_dly     <= DLY_INIT;
        r_dly_o   <= DLY_INIT;
        r_rstb_o  <= 1'b0;
        r_byp_o   <= 1'b1;
        r_lck_o   <= 1'b0;
        r_flt_o   <= 1'b0;
      end else begin
        r_sync1   <= LOCK_IN[c];
        r_sync2   <= r_sync1;
        r_state   <= w_state_nxt;
        r_rst_cnt <= w_rst_cnt_nxt;
        r_flt_cnt <= w_flt_cnt_nxt;
        r_tmo_cnt <= w_tmo_cnt_nxt;
        r_retry   <= w_retry_nxt;
        if (w_wr) r_dly <= DLY_DATA;
        r_dly_o   <= r_dly;
        r_rstb_o  <= (r_state == ST_WAIT) || (r_state == ST_LOCKED);
        r_byp_o   <= !((r_state == ST_WAIT) || (r_state == ST_LOCKED));
        r_lck_o   <= (r_state == ST_LOCKED);
        r_flt_o   <= (r_state == ST_FAULT);
      end
    end

    // Counters default to zero so they clear on every state exit and never wrap.
    always_comb begin
      w_state_nxt   = r_state;
      w_rst_cnt_nxt = '0;
      w_flt_cnt_nxt = '0;
      w_tmo_cnt_nxt = '0;
      w_retry_nxt   = r_retry;
      case (r_state)
        ST_OFF: begin
          w_retry_nxt = '0;
          if (ENABLE[c]) w_state_nxt = ST_RESET;
        end
        ST_RESET: begin
          if (r_rst_cnt == RC_LAST) w_state_nxt = ST_WAIT;
          else                      w_rst_cnt_nxt = r_rst_cnt + 1'b1;
        end
        ST_WAIT: begin
          if (w_wr) begin
            w_state_nxt = ST_RESET;
            w_retry_nxt = '0;
          end else if (r_sync2 && (r_flt_cnt == FC_LAST)) begin
            w_state_nxt = ST_LOCKED;
            w_retry_nxt = '0;
          end else if (r_tmo_cnt == TC_LAST) begin
            w_retry_nxt = r_retry + 1'b1;
            w_state_nxt = (r_retry == RT_LAST) ? ST_FAULT : ST_RESET;
          end else begin
            w_flt_cnt_nxt = r_sync2 ? (r_flt_cnt + 1'b1) : '0;
            w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (w_wr) begin
            w_state_nxt = ST_RESET;
            w_retry_nxt = '0;
          end else if (!r_sync2) begin
            w_state_nxt = ST_RESET;
          end
        end
        ST_FAULT: w_state_nxt = ST_FAULT;
        default:  w_state_nxt = ST_OFF;
      endcase
      if (!ENABLE[c]) begin
        w_state_nxt   = ST_OFF;
        w_rst_cnt_nxt = '0;
        w_flt_cnt_nxt = '0;
        w_tmo_cnt_nxt = '0;
      end
    end

    assign PLL_RESETB[c]         = r_rstb_o;
    assign BYPASS[c]             = r_byp_o;
    assign LOCKED[c]             = r_lck_o;
    assign FAULT[c]              = r_flt_o;
    assign DYNAMICDELAY[8*c +: 8] = r_dly_o;
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: nominal/glitchy lock, loss of lock,
// retry to fault, delay writes and asynchronous reset.
module tb_pll_lock_supervisor;

  logic        CLK;
  logic        RESETB;
  logic [1:0]  ENABLE;
  logic [1:0]  LOCK_IN;
  logic        DLY_WE;
  logic [1:0]  DLY_CH;
  logic [7:0]  DLY_DATA;
  logic [1:0]  PLL_RESETB;
  logic [1:0]  BYPASS;
  logic [15:0] DYNAMICDELAY;
  logic [1:0]  LOCKED;
  logic [1:0]  FAULT;

  int n_chk = 0;
  int n_err = 0;

  pll_lock_supervisor #(
    .NCH(2), .RST_CYCLES(4), .LOCK_FILT(8), .LOCK_TIMEOUT(64),
    .MAX_RETRY(3), .DLY_INIT(8'h3C)
  ) u_dut (
    .CLK(CLK), .RESETB(RESETB), .ENABLE(ENABLE), .LOCK_IN(LOCK_IN),
    .DLY_WE(DLY_WE), .DLY_CH(DLY_CH), .DLY_DATA(DLY_DATA),
    .PLL_RESETB(PLL_RESETB), .BYPASS(BYPASS), .DYNAMICDELAY(DYNAMICDELAY),
    .LOCKED(LOCKED), .FAULT(FAULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rstb"}, 32'(PLL_RESETB), 32'h0);
    chk({tag, "_byp"},  32'(BYPASS), 32'h3);
    chk({tag, "_lck"},  32'(LOCKED), 32'h0);
    chk({tag, "_flt"},  32'(FAULT), 32'h0);
    chk({tag, "_dly"},  32'(DYNAMICDELAY), 32'h3C3C);
  endtask

  initial begin
    RESETB = 1'b1; ENABLE = '0; LOCK_IN = '0;
    DLY_WE = 1'b0; DLY_CH = '0; DLY_DATA = '0;
    #1 RESETB = 1'b0;
    #1;
    chk_reset_vals("por");
    tick(2);
    RESETB = 1'b1;
    tick(2);
    chk_reset_vals("idle");

    // Nominal lock on channel 0
    ENABLE = 2'b01;
    tick(1);
    chk("nom_rst_t0", 32'(PLL_RESETB[0]), 32'h0);
    tick(4);
    chk("nom_rst_t4", 32'(PLL_RESETB[0]), 32'h0);
    tick(1);
    chk("nom_rstb_t5", 32'(PLL_RESETB[0]), 32'h1);
    chk("nom_byp_t5", 32'(BYPASS[0]), 32'h0);
    LOCK_IN[0] = 1'b1;
    tick(10);
    chk("nom_lck_e9", 32'(LOCKED[0]), 32'h0);
    tick(1);
    chk("nom_lck_e10", 32'(LOCKED[0]), 32'h1);
    chk("nom_ch1_rstb", 32'(PLL_RESETB[1]), 32'h0);
    chk("nom_ch1_byp", 32'(BYPASS[1]), 32'h1);
    chk("nom_ch1_lck", 32'(LOCKED[1]), 32'h0);
    chk("nom_ch1_flt", 32'(FAULT[1]), 32'h0);

    // Loss of lock: one low sample
    LOCK_IN[0] = 1'b0;
    tick(1);
    LOCK_IN[0] = 1'b1;
    tick(2);
    chk("lol_lck_l2", 32'(LOCKED[0]), 32'h1);
    tick(1);
    chk("lol_lck_l3", 32'(LOCKED[0]), 32'h0);
    chk("lol_rstb_l3", 32'(PLL_RESETB[0]), 32'h0);
    tick(3);
    chk("lol_rstb_l6", 32'(PLL_RESETB[0]), 32'h0);
    tick(1);
    chk("lol_rstb_l7", 32'(PLL_RESETB[0]), 32'h1);
    tick(7);
    chk("lol_lck_l14", 32'(LOCKED[0]), 32'h0);
    tick(1);
    chk("lol_lck_l15", 32'(LOCKED[0]), 32'h1);
    chk("lol_flt", 32'(FAULT[0]), 32'h0);

    // Glitchy lock on channel 1
    ENABLE = 2'b11;
    tick(6);
    chk("gl_rstb", 32'(PLL_RESETB[1]), 32'h1);
    LOCK_IN[1] = 1'b1;
    tick(7);
    LOCK_IN[1] = 1'b0;
    tick(1);
    LOCK_IN[1] = 1'b1;
    tick(4);
    chk("gl_lck_mid", 32'(LOCKED[1]), 32'h0);
    tick(6);
    chk("gl_lck_r9", 32'(LOCKED[1]), 32'h0);
    tick(1);
    chk("gl_lck_r10", 32'(LOCKED[1]), 32'h1);

    // Delay write to a locked channel forces relock
    DLY_WE = 1'b1; DLY_CH = 2'd1; DLY_DATA = 8'hA5;
    tick(1);
    DLY_WE = 1'b0;
    chk("dw_dly_w0", 32'(DYNAMICDELAY), 32'h3C3C);
    chk("dw_rstb_w0", 32'(PLL_RESETB[1]), 32'h1);
    tick(1);
    chk("dw_dly_w1", 32'(DYNAMICDELAY), 32'hA53C);
    chk("dw_rstb_w1", 32'(PLL_RESETB[1]), 32'h0);
    chk("dw_lck_w1", 32'(LOCKED), 32'h1);
    tick(11);
    chk("dw_lck_w12", 32'(LOCKED[1]), 32'h0);
    tick(1);
    chk("dw_lck_w13", 32'(LOCKED[1]), 32'h1);

    // Out-of-range channel write is ignored
    DLY_WE = 1'b1; DLY_CH = 2'd2; DLY_DATA = 8'h5A;
    tick(1);
    DLY_WE = 1'b0;
    tick(3);
    chk("oor_dly", 32'(DYNAMICDELAY), 32'hA53C);
    chk("oor_lck", 32'(LOCKED), 32'h3);
    chk("oor_rstb", 32'(PLL_RESETB), 32'h3);

    // Retry to fault on channel 0 with LOCK_IN held low
    ENABLE[0] = 1'b0; LOCK_IN[0] = 1'b0;
    tick(3);
    chk("off_rstb", 32'(PLL_RESETB[0]), 32'h0);
    chk("off_byp", 32'(BYPASS[0]), 32'h1);
    chk("off_lck", 32'(LOCKED[0]), 32'h0);
    ENABLE[0] = 1'b1;
    tick(1);
    tick(5);
    chk("rt_rise1", 32'(PLL_RESETB[0]), 32'h1);
    tick(63);
    chk("rt_hold1", 32'(PLL_RESETB[0]), 32'h1);
    tick(1);
    chk("rt_fall1", 32'(PLL_RESETB[0]), 32'h0);
    chk("rt_flt1", 32'(FAULT[0]), 32'h0);
    tick(3);
    chk("rt_pulse1", 32'(PLL_RESETB[0]), 32'h0);
    tick(1);
    chk("rt_rise2", 32'(PLL_RESETB[0]), 32'h1);
    tick(63);
    chk("rt_hold2", 32'(PLL_RESETB[0]), 32'h1);
    tick(1);
    chk("rt_fall2", 32'(PLL_RESETB[0]), 32'h0);
    tick(4);
    chk("rt_rise3", 32'(PLL_RESETB[0]), 32'h1);
    tick(63);
    chk("rt_flt_pre", 32'(FAULT[0]), 32'h0);
    tick(1);
    chk("rt_flt", 32'(FAULT[0]), 32'h1);
    chk("rt_flt_byp", 32'(BYPASS[0]), 32'h1);
    chk("rt_flt_rstb", 32'(PLL_RESETB[0]), 32'h0);
    tick(20);
    chk("rt_flt_hold", 32'(FAULT[0]), 32'h1);
    chk("rt_flt_rstb2", 32'(PLL_RESETB[0]), 32'h0);
    chk("rt_ch1_lck", 32'(LOCKED[1]), 32'h1);
    chk("rt_ch1_flt", 32'(FAULT[1]), 32'h0);

    // Disable clears fault; re-enable gets a fresh budget
    ENABLE[0] = 1'b0;
    tick(1);
    chk("dis_flt_s0", 32'(FAULT[0]), 32'h1);
    tick(1);
    chk("dis_flt_s1", 32'(FAULT[0]), 32'h0);
    chk("dis_byp", 32'(BYPASS[0]), 32'h1);
    ENABLE[0] = 1'b1;
    tick(1);
    tick(68);
    chk("re_hold", 32'(PLL_RESETB[0]), 32'h1);
    tick(1);
    chk("re_fall", 32'(PLL_RESETB[0]), 32'h0);
    chk("re_flt", 32'(FAULT[0]), 32'h0);
    tick(4);
    chk("re_rise", 32'(PLL_RESETB[0]), 32'h1);
    chk("re_flt2", 32'(FAULT[0]), 32'h0);

    // Asynchronous reset mid-WAIT_LOCK, no clock edge involved
    #2 RESETB = 1'b0;
    #1;
    chk_reset_vals("arst");
    RESETB = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
